// File: rtl/aes_pkg.sv
// Shared AES key-expansion types and helpers: key-length encoding, per-length
// word/round counts and the GF(2^8) doubling used for rcon and InvMixColumns.
package aes_pkg;

  typedef enum logic [1:0] {
    K128 = 2'b00,
    K192 = 2'b01,
    K256 = 2'b10,
    KRSV = 2'b11
  } keylen_t;

  localparam int NR_MAX = 14;
  localparam int NW_MAX = 60;

  // Number of 32-bit key words (Nk) for a key length
  function automatic logic [3:0] nk_of(input keylen_t m);
    case (m)
      K192:    nk_of = 4'd6;
      K256:    nk_of = 4'd8;
      default: nk_of = 4'd4;
    endcase
  endfunction

  // Number of cipher rounds (Nr) for a key length
  function automatic logic [3:0] nr_of(input keylen_t m);
    case (m)
      K192:    nr_of = 4'd12;
      K256:    nr_of = 4'd14;
      default: nr_of = 4'd10;
    endcase
  endfunction

  // Key width in bits; reserved encoding reports 0
  function automatic int keybits_of(input keylen_t m);
    case (m)
      K128:    keybits_of = 128;
      K192:    keybits_of = 192;
      K256:    keybits_of = 256;
      default: keybits_of = 0;
    endcase
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/key_word_step.sv
// One step of the AES key expansion: w[i] from w[i-1], w[i-Nk], the wrap
// position j = i mod Nk, Nk and the current rcon. Purely combinational.
module key_word_step (
  input  logic [31:0] prev,
  input  logic [31:0] old,
  input  logic [2:0]  j,
  input  logic [3:0]  nk,
  input  logic [7:0]  rcon,
  output logic [31:0] word
);

  logic [31:0] rot;
  logic [31:0] sub_in;
  logic [31:0] sub_out;

  // RotWord is pure wiring; the S-box is shared between the j=0 and j=4 cases
  assign rot = {prev[23:0], prev[31:24]};
  assign sub_in = (j == 3'd0) ? rot : prev;

  subword u_subword (
    .word_in  (sub_in),
    .word_out (sub_out)
  );

  // Select the temp word and fold in w[i-Nk]
  always_comb begin
    word = old ^ prev;
    if (j == 3'd0) begin
      word = old ^ sub_out ^ {rcon, 24'h0};
    end else if ((nk == 4'd8) && (j == 3'd4)) begin
      word = old ^ sub_out;
    end
  end

endmodule

// File: rtl/subword.sv
// SubWord: AES S-box applied independently to each byte of a 32-bit word.
module subword (
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Byte-wise table lookup
  always_comb begin
    word_out = {SBOX[word_in[31:24]], SBOX[word_in[23:16]],
                SBOX[word_in[15:8]],  SBOX[word_in[7:0]]};
  end

endmodule

// File: rtl/key_schedule.sv
// Run-time selectable AES key expansion (128/192/256) with an indexed round
// key store readable in any order while later rounds are still generated.
// Optional macro KEYSCHED_EQINV_EN adds rd_inv, which returns InvMixColumns of
// middle round keys for the equivalent inverse cipher.
module key_schedule
  import aes_pkg::*;
#(
  parameter int KMAX = 256,
  parameter int IDXW = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      mode,
  input  logic [KMAX-1:0] key,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [3:0]      nr,
  input  logic            rd_en,
  input  logic [IDXW-1:0] rd_idx,
`ifdef KEYSCHED_EQINV_EN
  input  logic            rd_inv,
`endif
  output logic [127:0]    rd_key,
  output logic            rd_valid
);

  typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;

  localparam int DEPTH = 2 ** IDXW;

  state_t         state, state_nxt;
  keylen_t        mode_k;
  logic           mode_legal, accept, reject;
  logic           gen, key_phase, last_word;
  logic [3:0]     nk;
  logic [5:0]     cnt, nw;
  logic [2:0]     j;
  logic [7:0]     rcon;
  logic [DEPTH-1:0] valid;
  logic [31:0]    key_words [8];
  logic [31:0]    win [8];
  logic [31:0]    acc [3];
  logic [127:0]   store [DEPTH];
  logic [31:0]    step_word, gen_word;
  logic           idx_ok, rd_hit;
  logic [127:0]   rd_word, rd_data;

`ifdef KEYSCHED_EQINV_EN
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] c);
    logic [7:0] a2, a4, a8;
    a2 = xtime(a);
    a4 = xtime(a2);
    a8 = xtime(a4);
    gmul = (c[0] ? a : 8'h00) ^ (c[1] ? a2 : 8'h00) ^
           (c[2] ? a4 : 8'h00) ^ (c[3] ? a8 : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    inv_mix_col = {gmul(a0, 4'd14) ^ gmul(a1, 4'd11) ^ gmul(a2, 4'd13) ^ gmul(a3, 4'd9),
                   gmul(a0, 4'd9)  ^ gmul(a1, 4'd14) ^ gmul(a2, 4'd11) ^ gmul(a3, 4'd13),
                   gmul(a0, 4'd13) ^ gmul(a1, 4'd9)  ^ gmul(a2, 4'd14) ^ gmul(a3, 4'd11),
                   gmul(a0, 4'd11) ^ gmul(a1, 4'd13) ^ gmul(a2, 4'd9)  ^ gmul(a3, 4'd14)};
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] k);
    inv_mix = {inv_mix_col(k[127:96]), inv_mix_col(k[95:64]),
               inv_mix_col(k[63:32]),  inv_mix_col(k[31:0])};
  endfunction
`endif

  // MSB-aligned key split into words; words beyond KMAX read as zero
  for (genvar g = 0; g < 8; g++) begin : g_kw
    if (g < KMAX / 32) begin : g_in
      assign key_words[g] = key[KMAX-1-32*g -: 32];
    end else begin : g_zero
      assign key_words[g] = '0;
    end
  end

  assign mode_k     = keylen_t'(mode);
  assign mode_legal = (mode_k != KRSV) && (keybits_of(mode_k) <= KMAX);
  assign accept     = start && !busy && mode_legal;
  assign reject     = start && !busy && !mode_legal;

  assign busy      = (state == GEN);
  assign done      = (state == DONE);
  assign gen       = (state == GEN);
  assign key_phase = ({2'b00, nk} > cnt);
  assign nw        = {nr + 4'd1, 2'b00};
  assign last_word = gen && (cnt == nw - 6'd1);

  // Window slots 0..Nk-1 hold w[i-Nk..i-1] once the key words are used up
  key_word_step u_step (
    .prev (win[3'(nk - 4'd1)]),
    .old  (win[0]),
    .j    (j),
    .nk   (nk),
    .rcon (rcon),
    .word (step_word)
  );

  assign gen_word = key_phase ? win[cnt[2:0]] : step_word;

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state: a legal start from IDLE or DONE launches a new expansion
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = GEN;
      GEN:     if (last_word) state_nxt = DONE;
      DONE:    if (accept) state_nxt = GEN;
      default: state_nxt = IDLE;
    endcase
  end

  // Control: latched mode, word/wrap counters, rcon, entry valid bits, err pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err   <= 1'b0;
      nr    <= 4'd0;
      nk    <= 4'd0;
      cnt   <= 6'd0;
      j     <= 3'd0;
      rcon  <= 8'h01;
      valid <= '0;
    end else begin
      err <= reject;
      if (accept) begin
        nk    <= nk_of(mode_k);
        nr    <= nr_of(mode_k);
        cnt   <= 6'd0;
        j     <= 3'd0;
        rcon  <= 8'h01;
        valid <= '0;
      end else if (gen) begin
        cnt <= cnt + 6'd1;
        j   <= (j == 3'(nk - 4'd1)) ? 3'd0 : j + 3'd1;
        if (!key_phase && (j == 3'd0)) rcon <= xtime(rcon);
        if (cnt[1:0] == 2'b11) valid[IDXW'(cnt[5:2])] <= 1'b1;
      end
    end
  end

  // Datapath: key window, 4-word packer and round key store (no reset needed)
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < 8; k++) win[k] <= key_words[k];
    end else if (gen) begin
      if (!key_phase) begin
        for (int m = 0; m < 7; m++) begin
          if (m < int'(nk) - 1) win[m] <= win[m+1];
        end
        win[3'(nk - 4'd1)] <= step_word;
      end
      case (cnt[1:0])
        2'd0:    acc[0] <= gen_word;
        2'd1:    acc[1] <= gen_word;
        2'd2:    acc[2] <= gen_word;
        default: store[IDXW'(cnt[5:2])] <= {acc[0], acc[1], acc[2], gen_word};
      endcase
    end
  end

  assign idx_ok  = (int'(rd_idx) <= int'(nr));
  assign rd_hit  = rd_en && idx_ok && valid[rd_idx];
  assign rd_word = store[rd_idx];

`ifdef KEYSCHED_EQINV_EN
  logic inv_sel;
  assign inv_sel = rd_inv && (rd_idx != '0) && (int'(rd_idx) < int'(nr));
  assign rd_data = inv_sel ? inv_mix(rd_word) : rd_word;
`else
  assign rd_data = rd_word;
`endif

  // ---- read stage p1: registered response, zero when not valid ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid <= 1'b0;
      rd_key   <= '0;
    end else begin
      rd_valid <= rd_hit;
      rd_key   <= rd_hit ? rd_data : '0;
    end
  end

endmodule

// File: doc/key_schedule.md
Name: key_schedule

Overview:
- Parametrised successor to the fixed-length AES key expansion.
- Key length (128/192/256) is selected at run time per start. Words are generated one per cycle and packed into 128-bit round keys.
- Round keys go into an internal indexed store, so the cipher datapath can read any round in any order: forward for encryption, reverse for decryption.
- Per-entry valid bits let the cipher start round 0 while later rounds are still being generated.

Parameters:
- KMAX, 256, widest supported key; legal values 128, 192, 256. Modes wider than KMAX are rejected.
- IDXW, 4, width of the round index; must satisfy 2**IDXW >= NR_MAX+1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request; sampled only when busy=0
- mode  in  2  key length: 00=128, 01=192, 10=256, 11=reserved
- key  in  KMAX  key, MSB-aligned; a 128-bit key occupies [KMAX-1:KMAX-128]
- busy  out  1  expansion in progress
- done  out  1  all round keys valid; held until the next accepted start
- err  out  1  one-cycle pulse: start with a reserved mode, or a mode wider than KMAX
- nr  out  4  round count of the latched mode (10/12/14)
- rd_en  in  1  read request
- rd_idx  in  IDXW  round index, 0..nr
- rd_key  out  128  round key, one cycle after rd_en
- rd_valid  out  1  qualifies rd_key, one cycle after rd_en

Behaviour:
- Reset (asynchronous, active-low): busy=0, done=0, err=0, nr=0, rd_valid=0, rd_key=0. All entry valid bits are cleared, the word counter is 0 and rcon=0x01. Reset during expansion aborts it; store contents become don't-care.
- Derived constants: Nk=4/6/8, Nr=10/12/14, NW=4*(Nr+1)=44/52/60.
- Accepting a start (cycle 0): requires start=1 and busy=0.
  - If mode is legal: latch key into an 8-word sliding window; latch Nk and Nr; clear all valid bits; done<=0; busy<=1.
  - If mode is illegal: err pulses in cycle 1; no other state changes.
- Start while busy=1 is ignored (no err).
- Generation, cycles 1..NW: cycle i+1 produces word w[i], i = 0..NW-1.
  - i < Nk: w[i] is key word i.
  - Otherwise let j = i mod Nk, tracked by a wrap counter rather than a divider, and t = w[i-1].
  - j=0: t = SubWord(RotWord(t)) ^ {rcon,24'h0}, then rcon <= xtime(rcon).
  - Nk=8 and j=4: t = SubWord(t).
  - w[i] = w[i-Nk] ^ t.
  - The window shifts by one word per cycle.
- Packing: a 4-word accumulator collects words.
  - On the edge ending cycle 4r+4, round key r is written to store entry r, with w[4r] in bits [127:96], and valid[r] is set.
  - valid[r] is observable from cycle 4r+5.
- Completion: busy falls and done rises in cycle NW+1. rcon resets to 0x01 on the next accepted start.
- Read port: registered, latency 1.
  - rd_valid = rd_en & valid[rd_idx] & (rd_idx <= nr).
  - An out-of-range index or an unwritten entry gives rd_valid=0 and rd_key=0.
  - A read of entry r in the same cycle that entry r is written returns rd_valid=0; the reader retries.
- Back-to-back operation: a start accepted while done=1 is legal and takes effect in the same cycle. Old keys are unreadable from cycle 1.

Optional Feature:
- Macro: KEYSCHED_EQINV_EN.
- Defined:
  - Adds input rd_inv (1 bit).
  - When rd_inv=1 and 1 <= rd_idx <= nr-1, rd_key = InvMixColumns(stored key), applied per 32-bit column, for the equivalent inverse cipher.
  - Indices 0 and nr are returned unmodified.
  - Read latency stays 1 cycle; the InvMixColumns logic sits after the RAM read and before the output register.
- Undefined: no rd_inv port and no InvMixColumns logic.

Decomposition:
- Shared package aes_pkg:
  - keylen_t enum (K128, K192, K256, KRSV).
  - Functions nk_of(), nr_of(), xtime().
  - Constants NR_MAX=14, NW_MAX=60.
- The existing subword module is reused.
- One natural sub-module, key_word_step: combinational w[i] from w[i-1], w[i-Nk], j, Nk and rcon. It contains the rotate and subword instances.
- The store, valid bits, counters and FSM (IDLE, GEN, DONE) live in key_schedule.

Test Plan:
- 128-bit FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c:
  - done at cycle 45; nr=10.
  - rd_idx=10 → d014f9a8c9ee2589e13f0cc8b6630ca6.
  - rd_idx=0 → the key itself.
- 192-bit key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - done at cycle 53.
  - rd_idx=12 → e98ba06f448c773c8ecc720401002202.
- 256-bit key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - done at cycle 61.
  - rd_idx=14 → fe4890d1e6188d0b046df344706c631e.
- Early read:
  - Poll rd_idx=1 from cycle 1 → rd_valid first 1 on the response to a read issued in cycle 9.
  - rd_idx=11 in 128 mode → rd_valid=0.
- Control corner cases:
  - start with mode=11 → err pulse, busy stays 0.
  - start at cycle 20 → ignored.
  - reset low at cycle 30 → busy=0 and done=0 immediately; the next start completes normally.
- With KEYSCHED_EQINV_EN defined, 128-bit key, rd_inv=1:
  - rd_idx=5 → InvMixColumns of the round-5 key.
  - rd_idx=0 and rd_idx=10 → unmodified keys.
